// File: rtl/crop_55.sv
// Border crop: strips a PAD-wide zero border from a padded raster stream and
// forwards only the interior D x D pixels, one cycle after each accepted beat.
module crop_55 #(
  parameter int unsigned D          = 35,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PAD        = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  valid_in_i,
  input  logic [DATA_WIDTH-1:0] pxl_in_i,
  output logic [DATA_WIDTH-1:0] pxl_out_o,
  output logic                  valid_out_o,
  output logic                  last_out_o,
  output logic                  frame_done_o,
  output logic                  busy_o
);

  localparam int unsigned P  = D + 2 * PAD;
  localparam int unsigned CW = $clog2(P);

  localparam logic [CW-1:0] PosMax  = CW'(P - 1);
  localparam logic [CW-1:0] InLo    = CW'(PAD);
  localparam logic [CW-1:0] InHi    = CW'(PAD + D);
  localparam logic [CW-1:0] InLast  = CW'(PAD + D - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                  state_q;
  logic [CW-1:0]           row_q, col_q;
  logic [DATA_WIDTH-1:0]   pxl_q;
  logic                    valid_q, last_q, done_q;

  logic col_end, frame_end, interior, is_last;

  always_comb begin
    col_end   = (col_q == PosMax);
    frame_end = col_end && (row_q == PosMax);
    interior  = (row_q >= InLo) && (row_q < InHi) && (col_q >= InLo) && (col_q < InHi);
    is_last   = (row_q == InLast) && (col_q == InLast);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      pxl_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Strobes are single-cycle; any cycle without an accepted beat drops them.
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      if (clear_i) begin
        state_q <= StIdle;
        row_q   <= '0;
        col_q   <= '0;
      end else if (valid_in_i) begin
        if (col_end) begin
          col_q <= '0;
          row_q <= frame_end ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (interior) begin
          pxl_q   <= pxl_in_i;
          valid_q <= 1'b1;
        end
        last_q <= is_last;
        if (frame_end) begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end else if (state_q == StIdle) begin
          state_q <= StActive;
        end
      end
    end
  end

  assign pxl_out_o    = pxl_q;
  assign valid_out_o  = valid_q;
  assign last_out_o   = last_q;
  assign frame_done_o = done_q;
  assign busy_o       = (state_q == StActive);

endmodule

// File: tb/tb_crop_55.sv
// Bench for crop_55: a small (D=3) and a default (D=35) instance share one
// input stream; each has its own scoreboard fed from frame-local beat indices.
module tb_crop_55;
  localparam int unsigned DW  = 32;
  localparam int unsigned PAD = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    int unsigned   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, clear, valid_in;
  logic [DW-1:0] pxl_in;
  logic [DW-1:0] po[2];
  logic          vo[2], lo[2], fd[2], bo[2];

  int unsigned   cyc = 0;
  int unsigned   n_chk = 0, n_fail = 0;
  exp_t          pix_q[2][$];
  int unsigned   done_q[2][$];
  int unsigned   kidx[2];
  logic          exp_busy[2];
  int unsigned   out_cnt[2], done_cnt[2];
  logic [DW-1:0] last_val[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crop_55 #(.D(3), .DATA_WIDTH(DW), .PAD(PAD)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_in_i(valid_in), .pxl_in_i(pxl_in),
    .pxl_out_o(po[0]), .valid_out_o(vo[0]), .last_out_o(lo[0]), .frame_done_o(fd[0]),
    .busy_o(bo[0])
  );

  crop_55 dut_l (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_in_i(valid_in), .pxl_in_i(pxl_in),
    .pxl_out_o(po[1]), .valid_out_o(vo[1]), .last_out_o(lo[1]), .frame_done_o(fd[1]),
    .busy_o(bo[1])
  );

  function automatic int unsigned geo_d(input int i);
    return (i == 0) ? 3 : 35;
  endfunction

  // Drive one cycle at the falling edge and predict what each instance emits.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic clr);
    int unsigned p, dd, r, c;
    @(negedge clk);
    valid_in = v;
    pxl_in   = d;
    clear    = clr;
    if (!rst_n) return;
    for (int i = 0; i < 2; i++) begin
      dd = geo_d(i);
      p  = dd + 2 * PAD;
      if (clr) begin
        kidx[i]     = 0;
        exp_busy[i] = 1'b0;
      end else if (v) begin
        r = kidx[i] / p;
        c = kidx[i] % p;
        if (r >= PAD && r < PAD + dd && c >= PAD && c < PAD + dd)
          pix_q[i].push_back('{data: d, last: (r == PAD + dd - 1 && c == PAD + dd - 1),
                               cyc: cyc + 1});
        if (kidx[i] == p * p - 1) begin
          done_q[i].push_back(cyc + 1);
          kidx[i]     = 0;
          exp_busy[i] = 1'b0;
        end else begin
          kidx[i]     = kidx[i] + 1;
          exp_busy[i] = 1'b1;
        end
      end
    end
  endtask

  // Scoreboard: sample just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    int unsigned dc;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        n_chk++;
        if (vo[i] !== 1'b0 || lo[i] !== 1'b0 || fd[i] !== 1'b0 || bo[i] !== 1'b0 ||
            po[i] !== '0) begin
          n_fail++;
          $display("FAIL in_reset[%0d]: got v=%b l=%b fd=%b busy=%b pxl=%0d, want all 0",
                   i, vo[i], lo[i], fd[i], bo[i], po[i]);
        end
      end else begin
        n_chk++;
        if (bo[i] !== exp_busy[i]) begin
          n_fail++;
          $display("FAIL busy[%0d] cyc %0d: got %b want %b", i, cyc, bo[i], exp_busy[i]);
        end
        if (vo[i] === 1'b1) begin
          out_cnt[i]++;
          n_chk++;
          if (pix_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL pixel[%0d] cyc %0d: got unexpected %0d, want none", i, cyc, po[i]);
          end else begin
            e = pix_q[i].pop_front();
            if (po[i] !== e.data || lo[i] !== e.last || cyc != e.cyc) begin
              n_fail++;
              $display("FAIL pixel[%0d]: got %0d last=%b cyc=%0d, want %0d last=%b cyc=%0d",
                       i, po[i], lo[i], cyc, e.data, e.last, e.cyc);
            end
          end
          if (lo[i] === 1'b1) last_val[i] = po[i];
        end else begin
          n_chk++;
          if (vo[i] !== 1'b0 || lo[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_strobes[%0d] cyc %0d: got v=%b l=%b, want 0 0",
                     i, cyc, vo[i], lo[i]);
          end
        end
        if (fd[i] !== 1'b0) begin
          done_cnt[i]++;
          n_chk++;
          if (done_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL frame_done[%0d] cyc %0d: got pulse, want none", i, cyc);
          end else begin
            dc = done_q[i].pop_front();
            if (fd[i] !== 1'b1 || cyc != dc) begin
              n_fail++;
              $display("FAIL frame_done[%0d]: got %b at cyc %0d, want 1 at cyc %0d",
                       i, fd[i], cyc, dc);
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0; pxl_in = '0;
    for (int i = 0; i < 2; i++) begin
      kidx[i] = 0; exp_busy[i] = 1'b0; out_cnt[i] = 0; done_cnt[i] = 0; last_val[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    n_chk++;
    if (out_cnt[0] != 0 || out_cnt[1] != 0 || po[0] !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got outs %0d/%0d pxl %0d, want 0/0 pxl 0",
               out_cnt[0], out_cnt[1], po[0]);
    end
  endtask

  task automatic test_single_frame;
    int unsigned o0 = out_cnt[0], d0 = done_cnt[0];
    for (int b = 0; b < 49; b++) drive(1'b1, DW'(b), 1'b0);
    idle(3);
    n_chk++;
    if (out_cnt[0] - o0 != 9 || done_cnt[0] - d0 != 1 || last_val[0] !== 32 ||
        pix_q[0].size() != 0) begin
      n_fail++;
      $display("FAIL single_frame: got outs=%0d done=%0d last=%0d left=%0d, want 9 1 32 0",
               out_cnt[0] - o0, done_cnt[0] - d0, last_val[0], pix_q[0].size());
    end
  endtask

  task automatic test_gaps;
    int unsigned o0 = out_cnt[0], d0 = done_cnt[0];
    for (int b = 0; b < 49; b++) begin
      drive(1'b1, DW'(b), 1'b0);
      idle(1);
    end
    idle(2);
    n_chk++;
    if (out_cnt[0] - o0 != 9 || done_cnt[0] - d0 != 1 || pix_q[0].size() != 0) begin
      n_fail++;
      $display("FAIL gaps: got outs=%0d done=%0d left=%0d, want 9 1 0",
               out_cnt[0] - o0, done_cnt[0] - d0, pix_q[0].size());
    end
  endtask

  task automatic test_back_to_back;
    int unsigned o0 = out_cnt[0], d0 = done_cnt[0];
    for (int b = 0; b < 98; b++) drive(1'b1, DW'(b), 1'b0);
    idle(3);
    n_chk++;
    if (out_cnt[0] - o0 != 18 || done_cnt[0] - d0 != 2 || last_val[0] !== 81 ||
        done_q[0].size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back: got outs=%0d done=%0d last=%0d, want 18 2 81",
               out_cnt[0] - o0, done_cnt[0] - d0, last_val[0]);
    end
  endtask

  task automatic test_clear;
    int unsigned o0 = out_cnt[0], d0 = done_cnt[0];
    for (int b = 0; b < 20; b++) drive(1'b1, DW'(b), 1'b0);
    drive(1'b1, DW'(20), 1'b1);
    idle(1);
    n_chk++;
    if (out_cnt[0] - o0 != 3 || bo[0] !== 1'b0 || bo[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_abort: got outs=%0d busy=%b/%b, want 3 0/0",
               out_cnt[0] - o0, bo[0], bo[1]);
    end
    for (int b = 0; b < 49; b++) drive(1'b1, DW'(100 + b), 1'b0);
    idle(3);
    n_chk++;
    if (out_cnt[0] - o0 != 12 || done_cnt[0] - d0 != 1 || last_val[0] !== 132) begin
      n_fail++;
      $display("FAIL clear_refill: got outs=%0d done=%0d last=%0d, want 12 1 132",
               out_cnt[0] - o0, done_cnt[0] - d0, last_val[0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    int unsigned o0, d0;
    for (int b = 0; b < 30; b++) drive(1'b1, DW'(b), 1'b0);
    @(negedge clk);
    rst_n = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin kidx[i] = 0; exp_busy[i] = 1'b0; end
    #1;
    n_chk++;
    if (vo[0] !== 1'b0 || bo[0] !== 1'b0 || po[0] !== '0 || bo[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b busy=%b pxl=%0d, want 0 0 0", vo[0], bo[0], po[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    o0 = out_cnt[0]; d0 = done_cnt[0];
    for (int b = 0; b < 49; b++) drive(1'b1, DW'(200 + b), 1'b0);
    idle(3);
    n_chk++;
    if (out_cnt[0] - o0 != 9 || done_cnt[0] - d0 != 1 || last_val[0] !== 232) begin
      n_fail++;
      $display("FAIL reset_refill: got outs=%0d done=%0d last=%0d, want 9 1 232",
               out_cnt[0] - o0, done_cnt[0] - d0, last_val[0]);
    end
  endtask

  task automatic test_default_size;
    int unsigned o1, d1;
    drive(1'b0, '0, 1'b1);
    o1 = out_cnt[1]; d1 = done_cnt[1];
    for (int b = 0; b < 1521; b++) drive(1'b1, DW'(b), 1'b0);
    idle(3);
    n_chk++;
    if (out_cnt[1] - o1 != 1225 || done_cnt[1] - d1 != 1 || last_val[1] !== 1440 ||
        pix_q[1].size() != 0 || done_q[1].size() != 0) begin
      n_fail++;
      $display("FAIL default_size: got outs=%0d done=%0d last=%0d, want 1225 1 1440",
               out_cnt[1] - o1, done_cnt[1] - d1, last_val[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_reset_mid_frame();
    test_default_size();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
